rtc_lectura_secuencia: RTL

Bus-side read sequencer for the RTC controller. On a start pulse it reads the six time and date registers of the external RTC over the multiplexed 8-bit address/data bus: seconds, minutes, hours, day, month and year. Each register is fetched with an address phase followed by a data phase. Each returned byte is presented as a registered BCD value with an index and a one-cycle valid strobe. The block sits directly upstream of the BCD-to-binary converter, and its `dato_bcd` output drives that converter's input.

---
 rtl/rtc_lectura_secuencia.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rtc_lectura_secuencia.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_lectura_secuencia
//  Purpose  : Reads the six RTC time/date registers over the multiplexed
//             address/data bus and hands each byte on as registered BCD.
//  Revision : 1.0  initial release
// ============================================================================
module rtc_lectura_secuencia #(
   parameter int         T_FASE   = 5,
   parameter logic [7:0] DIR_BASE = 8'h21
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       a_d,
   output logic [7:0] dato_bcd,
   output logic [2:0] indice,
   output logic       dato_valido,
   output logic       bcd_error,
   output logic       ocupado,
   output logic       fin
);

   localparam logic [3:0] C_FASE_ULT = 4'(T_FASE - 1);
   localparam logic [2:0] C_REG_ULT  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DIR     = 3'd1,
      S_ESPERA  = 3'd2,
      S_LEE     = 3'd3,
      S_ENTREGA = 3'd4
   } estado_t;

   estado_t    state_q, state_d;
   logic [3:0] fase_q, fase_d;
   logic [2:0] reg_cnt_q, reg_cnt_d;
   logic [7:0] ad_out_q, ad_out_d;
   logic       ad_oe_q, ad_oe_d;
   logic       cs_n_q, cs_n_d;
   logic       rd_n_q, rd_n_d;
   logic       wr_n_q, wr_n_d;
   logic       a_d_q, a_d_d;
   logic [7:0] dato_bcd_q, dato_bcd_d;
   logic [2:0] indice_q, indice_d;
   logic       dato_valido_q, dato_valido_d;
   logic       bcd_error_q, bcd_error_d;
   logic       ocupado_q, ocupado_d;
   logic       fin_q, fin_d;

   always_comb begin
      state_d       = state_q;
      fase_d        = fase_q;
      reg_cnt_d     = reg_cnt_q;
      dato_bcd_d    = dato_bcd_q;
      indice_d      = indice_q;
      bcd_error_d   = bcd_error_q;
      dato_valido_d = 1'b0;
      fin_d         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (iniciar) begin
               reg_cnt_d = 3'd0;
               fase_d    = 4'd0;
               state_d   = S_DIR;
            end
         end
         S_DIR: begin
            if (fase_q == C_FASE_ULT) begin
               fase_d  = 4'd0;
               state_d = S_ESPERA;
            end else begin
               fase_d = fase_q + 4'd1;
            end
         end
         S_ESPERA: begin
            fase_d  = 4'd0;
            state_d = S_LEE;
         end
         S_LEE: begin
            if (fase_q == C_FASE_ULT) begin
               // Sampled at the end of the read strobe, when the RTC output is settled.
               fase_d        = 4'd0;
               dato_bcd_d    = ad_in;
               indice_d      = reg_cnt_q;
               bcd_error_d   = (ad_in[7:4] > 4'd9) | (ad_in[3:0] > 4'd9);
               dato_valido_d = 1'b1;
               fin_d         = (reg_cnt_q == C_REG_ULT);
               state_d       = S_ENTREGA;
            end else begin
               fase_d = fase_q + 4'd1;
            end
         end
         S_ENTREGA: begin
            if (reg_cnt_q == C_REG_ULT) begin
               state_d = S_IDLE;
            end else begin
               reg_cnt_d = reg_cnt_q + 3'd1;
               state_d   = S_DIR;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Bus controls are decoded from the next state so they leave the flops
      // aligned with the state they belong to.
      cs_n_d    = !((state_d == S_DIR) || (state_d == S_LEE));
      wr_n_d    = (state_d != S_DIR);
      rd_n_d    = (state_d != S_LEE);
      a_d_d     = (state_d == S_DIR);
      ad_oe_d   = (state_d == S_DIR);
      ad_out_d  = (state_d == S_DIR) ? (DIR_BASE + {5'd0, reg_cnt_d}) : 8'h00;
      ocupado_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         fase_q        <= 4'd0;
         reg_cnt_q     <= 3'd0;
         ad_out_q      <= 8'h00;
         ad_oe_q       <= 1'b0;
         cs_n_q        <= 1'b1;
         rd_n_q        <= 1'b1;
         wr_n_q        <= 1'b1;
         a_d_q         <= 1'b0;
         dato_bcd_q    <= 8'h00;
         indice_q      <= 3'd0;
         dato_valido_q <= 1'b0;
         bcd_error_q   <= 1'b0;
         ocupado_q     <= 1'b0;
         fin_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         fase_q        <= fase_d;
         reg_cnt_q     <= reg_cnt_d;
         ad_out_q      <= ad_out_d;
         ad_oe_q       <= ad_oe_d;
         cs_n_q        <= cs_n_d;
         rd_n_q        <= rd_n_d;
         wr_n_q        <= wr_n_d;
         a_d_q         <= a_d_d;
         dato_bcd_q    <= dato_bcd_d;
         indice_q      <= indice_d;
         dato_valido_q <= dato_valido_d;
         bcd_error_q   <= bcd_error_d;
         ocupado_q     <= ocupado_d;
         fin_q         <= fin_d;
      end
   end

   assign ad_out      = ad_out_q;
   assign ad_oe       = ad_oe_q;
   assign cs_n        = cs_n_q;
   assign rd_n        = rd_n_q;
   assign wr_n        = wr_n_q;
   assign a_d         = a_d_q;
   assign dato_bcd    = dato_bcd_q;
   assign indice      = indice_q;
   assign dato_valido = dato_valido_q;
   assign bcd_error   = bcd_error_q;
   assign ocupado     = ocupado_q;
   assign fin         = fin_q;

endmodule
`default_nettype wire
